// File: rtl/pixel_window_fetch.sv
// pixel_window_fetch: streams 3x3 pixel windows for every pixel of an IMG_W x IMG_H frame
// Ports:
//   CK, RST            clock, synchronous active-high reset
//   start / busy / done frame request, frame in progress, end-of-frame pulse
//   mem_cs, mem_re,    synchronous memory read port; mem_dout is valid the
//   mem_raddr, mem_dout cycle after mem_re
//   win_valid/win_ready window handshake
//   win_data           tap k at bits [24k+23:24k], k = 3*(dy+1)+(dx+1)
//   win_x, win_y       centre-pixel coordinates of win_data
// Build option: BORDER_REPLICATE_EN clamps border taps to the nearest edge
// pixel instead of zero-padding them.
module pixel_window_fetch #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic         CK,
    input  logic         RST,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         mem_cs,
    output logic         mem_re,
    output logic [9:0]   mem_raddr,
    input  logic [23:0]  mem_dout,
    output logic         win_valid,
    input  logic         win_ready,
    output logic [215:0] win_data,
    output logic [9:0]   win_x,
    output logic [9:0]   win_y
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;
    state_t state, state_next;
    logic [9:0] x, y;
    logic [3:0] tap;
    logic [215:0] win;
    logic prev_rd;
    logic signed [11:0] dx, dy, cx, cy;
    logic [10:0] qx, qy;
    logic in_range, rd, last;
    // tap counts 0..8 while issuing; tap==9 is the extra cycle that captures tap 8
    always_comb begin
        dy = (tap < 4'd3) ? -12'sd1 : (tap < 4'd6) ? 12'sd0 : 12'sd1;
        dx = (tap == 4'd0 || tap == 4'd3 || tap == 4'd6) ? -12'sd1 :
             (tap == 4'd1 || tap == 4'd4 || tap == 4'd7) ? 12'sd0 : 12'sd1;
        cx = $signed({2'b00, x}) + dx;
        cy = $signed({2'b00, y}) + dy;
        in_range = !cx[11] && !cy[11] && cx[10:0] < 11'(IMG_W) && cy[10:0] < 11'(IMG_H);
        qx = cx[11] ? 11'd0 : (cx[10:0] >= 11'(IMG_W)) ? 11'(IMG_W - 1) : cx[10:0];
        qy = cy[11] ? 11'd0 : (cy[10:0] >= 11'(IMG_H)) ? 11'(IMG_H - 1) : cy[10:0];
`ifdef BORDER_REPLICATE_EN
        rd = state == FETCH && tap < 4'd9;
`else
        rd = state == FETCH && tap < 4'd9 && in_range;
`endif
        mem_cs = rd;
        mem_re = rd;
        mem_raddr = rd ? 10'(int'(qy) * IMG_W + int'(qx)) : '0;
        last = x == 10'(IMG_W - 1) && y == 10'(IMG_H - 1);
        busy = state == FETCH || state == HOLD;
        done = state == DONE;
        win_valid = state == HOLD;
        win_data = win_valid ? win : '0;
        win_x = win_valid ? x : '0;
        win_y = win_valid ? y : '0;
    end
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  state_next = start ? FETCH : IDLE;
            FETCH: state_next = (tap == 4'd9) ? HOLD : FETCH;
            HOLD:  state_next = win_ready ? (last ? DONE : FETCH) : HOLD;
            DONE:  state_next = IDLE;
        endcase
    end
    always_ff @(posedge CK) begin
        if (RST) begin
            state <= IDLE;
            x <= '0;
            y <= '0;
            tap <= '0;
            win <= '0;
            prev_rd <= 1'b0;
        end else begin
            state <= state_next;
            prev_rd <= rd;
            if (state == IDLE && start) begin
                x <= '0;
                y <= '0;
                tap <= '0;
            end
            if (state == FETCH) begin
                tap <= (tap == 4'd9) ? tap : tap + 4'd1;
                // slot k is filled one cycle after its issue; skipped taps store zero
                for (int k = 0; k < 9; k++)
                    if (tap == 4'(k + 1)) win[24*k +: 24] <= prev_rd ? mem_dout : 24'h000000;
            end
            if (state == HOLD && win_ready) begin
                tap <= '0;
                x <= (x == 10'(IMG_W - 1)) ? 10'd0 : x + 10'd1;
                y <= (x == 10'(IMG_W - 1)) ? y + 10'd1 : y;
            end
        end
    end
endmodule

// File: tb/tb_pixel_window_fetch.sv
// tb_pixel_window_fetch: directed self-checking bench for pixel_window_fetch
module tb_pixel_window_fetch;
    logic CK = 0, RST = 1, start = 0, win_ready = 0;
    logic busy, done, mem_cs, mem_re, win_valid;
    logic [9:0] mem_raddr, win_x, win_y;
    logic [23:0] mem_dout;
    logic [215:0] win_data, exp00;
    int errors = 0, checks = 0, hs_cnt = 0, done_cnt = 0, hs_base = 0, done_base = 0;

    pixel_window_fetch #(.IMG_W(32), .IMG_H(32)) dut (
        .CK(CK), .RST(RST), .start(start), .busy(busy), .done(done),
        .mem_cs(mem_cs), .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_dout(mem_dout),
        .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
        .win_x(win_x), .win_y(win_y)
    );

    always #5 CK = ~CK;

    // memory holds mem[a] = a; unread cycles return junk the DUT must ignore
    always @(posedge CK) mem_dout <= mem_re ? {14'd0, mem_raddr} : 24'hBADBAD;

    always @(posedge CK) begin
        if (win_valid && win_ready) hs_cnt <= hs_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task tick;
        @(posedge CK);
        #1;
    endtask

    task run_to(input int tx, input int ty);
        int n;
        n = 0;
        while (!(win_valid && win_x == 10'(tx) && win_y == 10'(ty)) && n < 20000) begin
            win_ready = 1;
            tick;
            n++;
        end
        win_ready = 0;
        checks++;
        if (n >= 20000) begin
            errors++;
            $display("FAIL run_to_timeout target=(%0d,%0d) got=(%0d,%0d)", tx, ty, win_x, win_y);
        end
    endtask

    task check_all_zero(input string tag);
        checks++;
        if ({busy, done, win_valid, mem_cs, mem_re} !== 5'b0) begin
            errors++;
            $display("FAIL %s_flags got=%b exp=00000", tag, {busy, done, win_valid, mem_cs, mem_re});
        end
        checks++;
        if (mem_raddr !== 10'd0) begin
            errors++;
            $display("FAIL %s_raddr got=%0d exp=0", tag, mem_raddr);
        end
        checks++;
        if (win_data !== 216'd0) begin
            errors++;
            $display("FAIL %s_win_data got=%h exp=0", tag, win_data);
        end
        checks++;
        if ({win_x, win_y} !== 20'd0) begin
            errors++;
            $display("FAIL %s_win_xy got=(%0d,%0d) exp=(0,0)", tag, win_x, win_y);
        end
    endtask

    task test_reset;
        RST = 1;
        start = 1;
        win_ready = 1;
        tick;
        tick;
        check_all_zero("reset");
        RST = 0;
        start = 0;
        win_ready = 0;
        tick;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_priority busy got=%b exp=0", busy);
        end
    endtask

    task test_first_window;
        int cyc, nre, ne, bad;
        logic [9:0] ra [0:15];
        logic [9:0] ea [0:8];
`ifdef BORDER_REPLICATE_EN
        ea = '{10'd0, 10'd0, 10'd1, 10'd0, 10'd0, 10'd1, 10'd32, 10'd32, 10'd33};
        ne = 9;
        exp00 = {24'd33, 24'd32, 24'd32, 24'd1, 24'd0, 24'd0, 24'd1, 24'd0, 24'd0};
`else
        ea = '{10'd0, 10'd1, 10'd32, 10'd33, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0};
        ne = 4;
        exp00 = {24'd33, 24'd32, 24'd0, 24'd1, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0};
`endif
        hs_base = hs_cnt;
        done_base = done_cnt;
        nre = 0;
        cyc = 0;
        start = 1;
        tick;
        start = 0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL start_busy got=%b exp=1", busy);
        end
        while (!win_valid && cyc < 50) begin
            if (mem_re) begin
                if (nre < 16) ra[nre] = mem_raddr;
                nre++;
            end
            tick;
            cyc++;
        end
        checks++;
        if (cyc !== 10) begin
            errors++;
            $display("FAIL first_latency got=%0d exp=10", cyc);
        end
        checks++;
        if (nre !== ne) begin
            errors++;
            $display("FAIL w00_read_count got=%0d exp=%0d", nre, ne);
        end
        bad = 0;
        for (int i = 0; i < ne; i++) if (ra[i] !== ea[i]) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL w00_read_addrs got=%0d wrong exp=0 wrong", bad);
        end
        checks++;
        if ({win_x, win_y} !== 20'd0) begin
            errors++;
            $display("FAIL w00_xy got=(%0d,%0d) exp=(0,0)", win_x, win_y);
        end
        checks++;
        if (win_data !== exp00) begin
            errors++;
            $display("FAIL w00_data got=%h exp=%h", win_data, exp00);
        end
    endtask

    task test_window_5_5;
        logic [215:0] e;
        for (int k = 0; k < 9; k++) e[24*k +: 24] = 24'((5 + k / 3 - 1) * 32 + 5 + k % 3 - 1);
        run_to(5, 5);
        checks++;
        if (win_data[96 +: 24] !== 24'h0000A5) begin
            errors++;
            $display("FAIL w55_centre got=%h exp=0000a5", win_data[96 +: 24]);
        end
        checks++;
        if (win_data !== e) begin
            errors++;
            $display("FAIL w55_data got=%h exp=%h", win_data, e);
        end
    endtask

    task test_stall;
        logic [215:0] d;
        logic [9:0] sx, sy;
        int bad, cyc;
        run_to(3, 7);
        checks++;
        if (win_data[96 +: 24] !== 24'd227) begin
            errors++;
            $display("FAIL w37_centre got=%0d exp=227", win_data[96 +: 24]);
        end
        d = win_data;
        sx = win_x;
        sy = win_y;
        bad = 0;
        repeat (20) begin
            tick;
            if (win_data !== d || win_x !== sx || win_y !== sy || win_valid !== 1'b1 ||
                mem_re !== 1'b0 || mem_cs !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL stall_stable got=%0d bad cycles exp=0", bad);
        end
        win_ready = 1;
        tick;
        win_ready = 0;
        cyc = 0;
        while (!win_valid && cyc < 50) begin
            tick;
            cyc++;
        end
        checks++;
        if ({win_x, win_y} !== {10'd4, 10'd7}) begin
            errors++;
            $display("FAIL stall_advance got=(%0d,%0d) exp=(4,7)", win_x, win_y);
        end
        checks++;
        if (win_data[96 +: 24] !== 24'd228) begin
            errors++;
            $display("FAIL w47_centre got=%0d exp=228", win_data[96 +: 24]);
        end
    endtask

    task test_full_frame;
        logic [23:0] e8;
`ifdef BORDER_REPLICATE_EN
        e8 = 24'd1023;
`else
        e8 = 24'd0;
`endif
        run_to(31, 31);
        checks++;
        if ({win_data[0 +: 24], win_data[96 +: 24], win_data[192 +: 24]} !== {24'd990, 24'd1023, e8}) begin
            errors++;
            $display("FAIL last_taps got=%0d,%0d,%0d exp=990,1023,%0d",
                     win_data[0 +: 24], win_data[96 +: 24], win_data[192 +: 24], e8);
        end
        win_ready = 1;
        tick;
        win_ready = 0;
        checks++;
        if ({done, busy} !== 2'b10) begin
            errors++;
            $display("FAIL done_pulse got done,busy=%b exp=10", {done, busy});
        end
        tick;
        checks++;
        if ({done, busy, win_valid} !== 3'b000) begin
            errors++;
            $display("FAIL after_done got=%b exp=000", {done, busy, win_valid});
        end
        repeat (5) tick;
        checks++;
        if (hs_cnt - hs_base !== 1024) begin
            errors++;
            $display("FAIL window_count got=%0d exp=1024", hs_cnt - hs_base);
        end
        checks++;
        if (done_cnt - done_base !== 1) begin
            errors++;
            $display("FAIL done_count got=%0d exp=1", done_cnt - done_base);
        end
    endtask

    task test_abort;
        int bad, cyc;
        start = 1;
        tick;
        start = 0;
        run_to(9, 2);
        win_ready = 1;
        tick;
        win_ready = 0;
        checks++;
        if ({mem_re, mem_raddr} !== {1'b1, 10'd41}) begin
            errors++;
            $display("FAIL w102_tap0 got re=%b addr=%0d exp re=1 addr=41", mem_re, mem_raddr);
        end
        repeat (4) tick;
        checks++;
        if ({mem_re, mem_raddr} !== {1'b1, 10'd74}) begin
            errors++;
            $display("FAIL w102_tap4 got re=%b addr=%0d exp re=1 addr=74", mem_re, mem_raddr);
        end
        RST = 1;
        tick;
        check_all_zero("abort");
        RST = 0;
        bad = 0;
        repeat (15) begin
            tick;
            if (busy || done || win_valid || mem_re) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL abort_quiet got=%0d active cycles exp=0", bad);
        end
        start = 1;
        tick;
        start = 0;
        cyc = 0;
        while (!win_valid && cyc < 50) begin
            start = (cyc == 2);
            tick;
            cyc++;
        end
        start = 0;
        checks++;
        if (cyc !== 10) begin
            errors++;
            $display("FAIL restart_latency got=%0d exp=10", cyc);
        end
        checks++;
        if ({win_x, win_y} !== 20'd0 || win_data !== exp00) begin
            errors++;
            $display("FAIL restart_w00 got=(%0d,%0d) %h exp=(0,0) %h", win_x, win_y, win_data, exp00);
        end
        win_ready = 1;
        tick;
        win_ready = 0;
        cyc = 0;
        while (!win_valid && cyc < 50) begin
            tick;
            cyc++;
        end
        checks++;
        if ({win_x, win_y, win_data[96 +: 24]} !== {10'd1, 10'd0, 24'd1} || cyc !== 10) begin
            errors++;
            $display("FAIL restart_w10 got=(%0d,%0d) centre=%0d lat=%0d exp=(1,0) centre=1 lat=10",
                     win_x, win_y, win_data[96 +: 24], cyc);
        end
        RST = 1;
        tick;
        RST = 0;
    endtask

    initial begin
        test_reset;
        test_first_window;
        test_window_5_5;
        test_stall;
        test_full_frame;
        test_abort;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
